// File: rtl/vend_session_arbiter_if.sv
// Panel-side bus of the vending session arbiter.
//   req/coin/cancel : per-panel requests, 2-bit coin codes and cancel buttons (panel -> arbiter)
//   grant           : one-hot session owner
//   busy            : engine is not idle
//   credit          : credit accumulated by the current owner
//   dispense        : one-cycle vend pulse
//   change          : refund/change amount, qualified by change_vld
interface vend_session_arbiter_if #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned CW   = 4
);
  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] coin;
  logic [NREQ-1:0]   cancel;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic [CW-1:0]     credit;
  logic              dispense;
  logic [CW-1:0]     change;
  logic              change_vld;

  modport master (
    output req, coin, cancel,
    input  grant, busy, credit, dispense, change, change_vld
  );

  modport slave (
    input  req, coin, cancel,
    output grant, busy, credit, dispense, change, change_vld
  );
endinterface

// File: rtl/vend_session_arbiter.sv
// Round-robin owner of a shared vending credit/dispense engine.
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : vend_session_arbiter_if slave side (panel requests in, grant/credit/vend/change out)
// A granted panel feeds coins until credit reaches PRICE (vend + change) or
// cancels / times out (full refund). All outputs are flops.
module vend_session_arbiter #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned PRICE   = 3,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CW      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  vend_session_arbiter_if.slave bus
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SESSION, VEND, REFUND} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   last_q, last_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [CW-1:0]   credit_q, credit_d;
  logic [CW-1:0]   change_q, change_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic            busy_q, busy_d;
  logic            dispense_q, dispense_d;
  logic            change_vld_q, change_vld_d;

  logic            found_c;
  logic [PW-1:0]   winner_c;
  logic [PW:0]     cand_c;
  logic [1:0]      coin_sel_c;
  logic            cancel_sel_c;
  logic [1:0]      add_c;
  logic            coin_ok_c;
  logic [CW-1:0]   credit_new_c;
  logic [TW-1:0]   timer_inc_c;

  // Round-robin search starting just after the last winner, wrapping at NREQ.
  always_comb begin
    found_c  = 1'b0;
    winner_c = last_q;
    cand_c   = '0;
    for (int i = 1; i <= int'(NREQ); i++) begin
      cand_c = {1'b0, last_q} + (PW+1)'(i);
      if (cand_c >= (PW+1)'(NREQ)) cand_c = cand_c - (PW+1)'(NREQ);
      if (!found_c && bus.req[cand_c[PW-1:0]]) begin
        found_c  = 1'b1;
        winner_c = cand_c[PW-1:0];
      end
    end
  end

  // Only the owner's coin/cancel matter; last_q holds the owner during a session.
  always_comb begin
    coin_sel_c   = bus.coin[{last_q, 1'b0} +: 2];
    cancel_sel_c = bus.cancel[last_q];
    unique case (coin_sel_c)
      2'b01:   add_c = 2'd1;
      2'b10:   add_c = 2'd2;
      default: add_c = 2'd0;
    endcase
    coin_ok_c    = (add_c != 2'd0);
    credit_new_c = credit_q + CW'(add_c);
    timer_inc_c  = timer_q + TW'(1);
  end

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    timer_d      = timer_q;
    credit_d     = credit_q;
    grant_d      = grant_q;
    change_d     = '0;
    dispense_d   = 1'b0;
    change_vld_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found_c) begin
          state_d           = SESSION;
          grant_d           = '0;
          grant_d[winner_c] = 1'b1;
          last_d            = winner_c;
          timer_d           = '0;
          credit_d          = '0;
        end
      end
      SESSION: begin
        credit_d = credit_new_c;
        timer_d  = coin_ok_c ? '0 : timer_inc_c;
        if (cancel_sel_c) begin
          state_d      = REFUND;
          change_d     = credit_new_c;
          change_vld_d = 1'b1;
        end else if (credit_new_c >= CW'(PRICE)) begin
          state_d      = VEND;
          change_d     = credit_new_c - CW'(PRICE);
          dispense_d   = 1'b1;
          change_vld_d = 1'b1;
        end else if (!coin_ok_c && (timer_inc_c == TW'(TIMEOUT))) begin
          state_d      = REFUND;
          change_d     = credit_new_c;
          change_vld_d = 1'b1;
        end
      end
      VEND, REFUND: begin
        state_d  = IDLE;
        grant_d  = '0;
        credit_d = '0;
        timer_d  = '0;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset makes panel 0 the first winner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_q       <= PW'(NREQ - 1);
      timer_q      <= '0;
      credit_q     <= '0;
      change_q     <= '0;
      grant_q      <= '0;
      busy_q       <= 1'b0;
      dispense_q   <= 1'b0;
      change_vld_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      timer_q      <= timer_d;
      credit_q     <= credit_d;
      change_q     <= change_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
      dispense_q   <= dispense_d;
      change_vld_q <= change_vld_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.busy       = busy_q;
  assign bus.credit     = credit_q;
  assign bus.dispense   = dispense_q;
  assign bus.change     = change_q;
  assign bus.change_vld = change_vld_q;

endmodule

// File: doc/vend_session_arbiter.md
Name: vend_session_arbiter

Overview:
- Shares one vending credit/dispense engine between NREQ front panels, each with its own coin acceptor and cancel button.
- A round-robin arbiter grants exclusive session ownership to one panel. The engine counts that panel's coins until credit reaches PRICE, then dispenses and returns change.
- Cancel or inactivity timeout refunds the full credit.
- Sits between the panel coin decoders and the dispense/change-return actuators.

Parameters:
- NREQ, 2: number of panels (requesters), 2 to 8.
- PRICE, 3: item price in coin units (1 unit = 5).
- TIMEOUT, 16: consecutive coinless SESSION cycles before auto-refund, at least 2.
- CW, 4: credit/change width; must hold PRICE+1.

Ports:
- clk, in, 1: system clock, rising edge.
- rst, in, 1: asynchronous, active-low reset.
- req, in, NREQ: per-panel session request, level.
- coin, in, 2*NREQ: per-panel coin code; panel i uses bits [2i+1:2i]. 00 = none, 01 = 1 unit, 10 = 2 units, 11 = invalid and ignored.
- cancel, in, NREQ: per-panel cancel, level.
- grant, out, NREQ: one-hot session owner, or all zeros.
- busy, out, 1: high in any state other than IDLE.
- credit, out, CW: current accumulated credit.
- dispense, out, 1: one-cycle vend pulse.
- change, out, CW: refund/change amount, valid when change_vld is high.
- change_vld, out, 1: one-cycle pulse accompanying every vend or refund.

Behaviour:
- **Reset values:** all outputs are registered. While rst is low: grant=0, busy=0, credit=0, dispense=0, change=0, change_vld=0, state=IDLE, and the last-winner pointer = NREQ-1 (so panel 0 has highest priority). Asserting reset mid-session discards credit silently, with no dispense or change pulse.
- **States:** IDLE, SESSION, VEND, REFUND.
- **IDLE:**
  - If any req is high at edge N, choose the first requester searching from last+1 upward, modulo NREQ.
  - At N+1: state=SESSION, grant is one-hot on the winner, pointer=winner, timer=0, credit=0.
  - There is no grant in the same cycle as the request.
- **SESSION:**
  - Only the granted panel's coin and cancel are sampled; other panels' inputs are ignored.
  - Coin 01 or 10 adds 1 or 2 to credit at the next edge and clears the timer.
  - Coin 00 or 11 increments the timer.
  - Dropping req during a session has no effect.
- **Transition priority in SESSION (one edge):**
  - (a) granted cancel high: go to REFUND. A coin presented in the same cycle is added and included in the refund.
  - (b) else, new credit >= PRICE: go to VEND.
  - (c) else, the timer reaches TIMEOUT on this coinless cycle: go to REFUND.
  - (d) else, stay in SESSION.
- **VEND (exactly 1 cycle):**
  - dispense=1, change_vld=1, change=credit-PRICE (can be 0).
  - grant is still held.
  - Next edge: state=IDLE, grant=0, credit=0, change=0.
- **REFUND (exactly 1 cycle):**
  - dispense=0, change_vld=1, change=credit (can be 0).
  - Next edge goes to IDLE, same clearing as VEND.
- **Latency:** a qualifying coin at edge t gives dispense high in cycle t+1 and grant low at t+2. The earliest re-grant is at t+3 (IDLE lasts at least one cycle).
- **Credit arithmetic:**
  - Credit is never above PRICE+1, since a coin is at most 2 units and VEND is entered at >= PRICE.
  - change = credit-PRICE, computed in CW bits, with no wrap.
- **Fairness:** the winner becomes lowest priority. With all panels requesting continuously, grants rotate 0,1,…,NREQ-1,0.

Test Plan:
- **Reset:** rst low mid-SESSION with credit=2 (PRICE=3, NREQ=2, TIMEOUT=8) -> all outputs 0 immediately, without waiting for a clock edge; no dispense or change_vld. After release, req=01 -> grant=01 one cycle later.
- **Exact price:** grant=01; coin0=01, then coin0=10 -> credit 1, 3; dispense=1, change_vld=1, change=0 for one cycle; then grant=00 and credit=0.
- **Overpay:** coin0=10, 10 -> credit 2, then 4 -> VEND with change=1. Coin 11 mid-session -> credit unchanged.
- **Arbitration:** req=11 from reset -> grant=01. After that session ends with req still 11 -> grant=10, then 01. Panel1 coins during panel0's session -> ignored.
- **Cancel:** credit=2, then cancel0 together with coin0=01 -> REFUND with change=3, change_vld=1, dispense=0. Cancel at credit=0 -> change_vld=1, change=0.
- **Timeout:** coin0=01, then 8 coinless cycles -> REFUND with change=1 in the following cycle. A coin on the 7th cycle -> timer restarts and there is no refund.
